// File: rtl/si5340_i2c_writer.sv
// rtl/si5340_i2c_writer.sv - Si5340 config writer: page-cached I2C register writes.
`timescale 1ns/1ps
module si5340_i2c_writer #(
  parameter int unsigned CLK_FREQ = 125_000_000,
  parameter int unsigned I2C_FREQ = 400_000,
  parameter logic [6:0]  DEV_ADDR = 7'h74,
  parameter logic [7:0]  PAGE_REG = 8'h01
) (
  input  logic        clk_i,
  input  logic        arstn_i,
  input  logic        cfg_valid_i,
  input  logic [23:0] cfg_data_i,
  output logic        cfg_ready_o,
  output logic        scl_oe_o,
  output logic        sda_oe_o,
  input  logic        sda_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        nack_o
);

  localparam int unsigned QTR = CLK_FREQ / (4 * I2C_FREQ);
  localparam int unsigned QW  = (QTR > 1) ? $clog2(QTR) : 1;
  localparam logic [QW-1:0] QTR_LAST = QW'(QTR - 1);

  typedef enum logic [2:0] {IDLE, START, BIT, ACK, STOP, GAP} state_e;

  state_e        st_q, st_d;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic [1:0]    tk_q, tk_d, byte_q, byte_d;
  logic [2:0]    bit_q, bit_d;
  logic [23:0]   word_q, word_d;
  logic [7:0]    cache_q, cache_d;
  logic          cache_vld_q, cache_vld_d, page_ph_q, page_ph_d;
  logic          ack_q, ack_d, nack_q, nack_d;
  logic          scl_oe_q, scl_oe_d, sda_oe_q, sda_oe_d;
  logic          ready_q, ready_d, busy_q, busy_d, done_q, done_d, nackp_q, nackp_d;
  logic          last_clk;
  logic [7:0]    tx_byte;

  always_comb begin
    st_d = st_q;  qcnt_d = qcnt_q;  tk_d = tk_q;  byte_d = byte_q;  bit_d = bit_q;
    word_d = word_q;  cache_d = cache_q;  cache_vld_d = cache_vld_q;  page_ph_d = page_ph_q;
    ack_d = ack_q;  nack_d = nack_q;  done_d = 1'b0;  nackp_d = 1'b0;
    last_clk = (qcnt_q == QTR_LAST);
    if (st_q != IDLE) begin
      qcnt_d = last_clk ? '0 : qcnt_q + 1'b1;
      if (last_clk) tk_d = tk_q + 2'd1;
    end
    case (st_q)
      IDLE: begin
        qcnt_d = '0;
        tk_d   = 2'd0;
        if (cfg_valid_i && ready_q) begin
          word_d    = cfg_data_i;
          page_ph_d = !cache_vld_q || (cfg_data_i[23:16] != cache_q);
          byte_d    = 2'd0;
          bit_d     = 3'd7;
          nack_d    = 1'b0;
          st_d      = START;
        end
      end
      START: if (last_clk && tk_q == 2'd1) begin
        st_d = BIT;
        tk_d = 2'd0;
      end
      BIT: if (last_clk && tk_q == 2'd3) begin
        bit_d = bit_q - 3'd1;
        if (bit_q == 3'd0) st_d = ACK;
      end
      ACK: begin
        if (last_clk && tk_q == 2'd2) ack_d = sda_i;
        if (last_clk && tk_q == 2'd3) begin
          if (ack_q) begin
            nack_d      = 1'b1;
            cache_vld_d = 1'b0;
            st_d        = STOP;
          end else if (byte_q == 2'd2) begin
            st_d = STOP;
            // Cache only trusts a page write the device fully acknowledged.
            if (page_ph_q) begin
              cache_d     = word_q[23:16];
              cache_vld_d = 1'b1;
            end
          end else begin
            byte_d = byte_q + 2'd1;
            bit_d  = 3'd7;
            st_d   = BIT;
          end
        end
      end
      STOP: if (last_clk && tk_q == 2'd3) begin
        if (nack_q) begin
          st_d = IDLE;  done_d = 1'b1;  nackp_d = 1'b1;
        end else if (page_ph_q) begin
          st_d = GAP;  page_ph_d = 1'b0;  byte_d = 2'd0;  bit_d = 3'd7;
        end else begin
          st_d = IDLE;  done_d = 1'b1;
        end
      end
      GAP: if (last_clk && tk_q == 2'd3) st_d = START;
      default: st_d = IDLE;
    endcase

    case (byte_d)
      2'd0:    tx_byte = {DEV_ADDR, 1'b0};
      2'd1:    tx_byte = page_ph_d ? PAGE_REG : word_d[15:8];
      default: tx_byte = page_ph_d ? word_d[23:16] : word_d[7:0];
    endcase

    // Pin drives follow the next state so they line up with the state registers.
    scl_oe_d = 1'b0;
    sda_oe_d = 1'b0;
    case (st_d)
      START: sda_oe_d = (tk_d == 2'd1);
      BIT: begin
        scl_oe_d = ~tk_d[1];
        sda_oe_d = ~tx_byte[bit_d];
      end
      ACK:  scl_oe_d = ~tk_d[1];
      STOP: begin
        scl_oe_d = (tk_d == 2'd0);
        sda_oe_d = ~tk_d[1];
      end
      default: ;
    endcase
    ready_d = (st_d == IDLE) && !done_d;
    busy_d  = (st_d != IDLE);
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      st_q <= IDLE;  qcnt_q <= '0;  tk_q <= 2'd0;  byte_q <= 2'd0;  bit_q <= 3'd7;
      word_q <= 24'd0;  cache_q <= 8'd0;  cache_vld_q <= 1'b0;  page_ph_q <= 1'b0;
      ack_q <= 1'b0;  nack_q <= 1'b0;  scl_oe_q <= 1'b0;  sda_oe_q <= 1'b0;
      ready_q <= 1'b1;  busy_q <= 1'b0;  done_q <= 1'b0;  nackp_q <= 1'b0;
    end else begin
      st_q <= st_d;  qcnt_q <= qcnt_d;  tk_q <= tk_d;  byte_q <= byte_d;  bit_q <= bit_d;
      word_q <= word_d;  cache_q <= cache_d;  cache_vld_q <= cache_vld_d;  page_ph_q <= page_ph_d;
      ack_q <= ack_d;  nack_q <= nack_d;  scl_oe_q <= scl_oe_d;  sda_oe_q <= sda_oe_d;
      ready_q <= ready_d;  busy_q <= busy_d;  done_q <= done_d;  nackp_q <= nackp_d;
    end
  end

  assign cfg_ready_o = ready_q;
  assign scl_oe_o    = scl_oe_q;
  assign sda_oe_o    = sda_oe_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign nack_o      = nackp_q;

endmodule

// File: tb/tb_si5340_i2c_writer.sv
// tb/tb_si5340_i2c_writer.sv - Bench for si5340_i2c_writer: waveform model, bus decoder, directed words.
`timescale 1ns/1ps
module tb_si5340_i2c_writer;

  localparam int unsigned CLK_FREQ = 8_000_000;
  localparam int unsigned I2C_FREQ = 400_000;
  localparam logic [6:0]  DEV_ADDR = 7'h74;
  localparam logic [7:0]  PAGE_REG = 8'h01;
  localparam int          QTR      = CLK_FREQ / (4 * I2C_FREQ);
  localparam logic [7:0]  ADDR_W   = {DEV_ADDR, 1'b0};

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        arstn_i = 1'b0;
  logic        cfg_valid_i = 1'b0;
  logic [23:0] cfg_data_i = 24'd0;
  logic        cfg_ready_o, scl_oe_o, sda_oe_o, sda_i, busy_o, done_o, nack_o;
  logic        slave_low = 1'b0;

  assign sda_i = ~(sda_oe_o | slave_low);

  si5340_i2c_writer #(
    .CLK_FREQ(CLK_FREQ), .I2C_FREQ(I2C_FREQ), .DEV_ADDR(DEV_ADDR), .PAGE_REG(PAGE_REG)
  ) dut (
    .clk_i(clk_i), .arstn_i(arstn_i), .cfg_valid_i(cfg_valid_i), .cfg_data_i(cfg_data_i),
    .cfg_ready_o(cfg_ready_o), .scl_oe_o(scl_oe_o), .sda_oe_o(sda_oe_o), .sda_i(sda_i),
    .busy_o(busy_o), .done_o(done_o), .nack_o(nack_o)
  );

  typedef struct packed {
    logic scl, sda, slv, ready, busy, done, nack;
  } ent_t;

  ent_t       exp_q[$];
  int         n_checks = 0, n_errors = 0;
  bit         mon_en = 1'b0;
  logic [7:0] m_cache = 8'd0;
  bit         m_vld = 1'b0;

  task automatic check_int(input string nm, input int act, input int exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp_v);
    end
  endtask

  // One quarter-bit of expected pin state, repeated for every clock of the quarter.
  function automatic void push(input logic scl, input logic sda, input logic slv);
    ent_t e;
    e = '0;
    e.scl = scl;  e.sda = sda;  e.slv = slv;  e.busy = 1'b1;
    for (int k = 0; k < QTR; k++) exp_q.push_back(e);
  endfunction

  function automatic void model_txn(input logic [7:0] b0, input logic [7:0] b1,
                                    input logic [7:0] b2, input int nb, output bit nk);
    logic [7:0] by [3];
    by[0] = b0;  by[1] = b1;  by[2] = b2;
    nk = 1'b0;
    push(1'b0, 1'b0, 1'b0);
    push(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      if (!nk) begin
        for (int b = 7; b >= 0; b--) begin
          push(1'b1, ~by[i][b], 1'b0);  push(1'b1, ~by[i][b], 1'b0);
          push(1'b0, ~by[i][b], 1'b0);  push(1'b0, ~by[i][b], 1'b0);
        end
        push(1'b1, 1'b0, i != nb);  push(1'b1, 1'b0, i != nb);
        push(1'b0, 1'b0, i != nb);  push(1'b0, 1'b0, i != nb);
        if (i == nb) nk = 1'b1;
      end
    end
    push(1'b1, 1'b1, 1'b0);  push(1'b0, 1'b1, 1'b0);
    push(1'b0, 1'b0, 1'b0);  push(1'b0, 1'b0, 1'b0);
  endfunction

  // ntx: 0 none, 1 page transaction, 2 data transaction; nb: byte slot the slave NACKs.
  function automatic void model_word(input logic [23:0] w, input int ntx, input int nb);
    bit   nk;
    ent_t e;
    nk = 1'b0;
    if (!m_vld || w[23:16] != m_cache) begin
      model_txn(ADDR_W, PAGE_REG, w[23:16], (ntx == 1) ? nb : -1, nk);
      if (!nk) begin
        m_cache = w[23:16];
        m_vld   = 1'b1;
        for (int g = 0; g < 4; g++) push(1'b0, 1'b0, 1'b0);
      end
    end
    if (!nk) model_txn(ADDR_W, w[15:8], w[7:0], (ntx == 2) ? nb : -1, nk);
    if (nk) m_vld = 1'b0;
    e = '0;
    e.done = 1'b1;
    e.nack = nk;
    exp_q.push_back(e);
  endfunction

  always @(negedge clk_i) begin
    ent_t       e;
    logic [5:0] got, want;
    if (mon_en) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else begin
        e = '0;
        e.ready = 1'b1;
      end
      slave_low = e.slv;
      got  = {scl_oe_o, sda_oe_o, cfg_ready_o, busy_o, done_o, nack_o};
      want = {e.scl, e.sda, e.ready, e.busy, e.done, e.nack};
      n_checks++;
      if (got !== want) begin
        n_errors++;
        $display("FAIL bus_cycle t=%0t scl,sda,rdy,busy,done,nack got %b want %b", $time, got, want);
      end
    end else begin
      slave_low = 1'b0;
    end
  end

  // Independent bus decoder: START/STOP detection and bit capture on SCL rising edges.
  logic       prev_scl = 1'b1, prev_sda = 1'b1;
  int         starts = 0, stops = 0, bitcnt = 0, rises = 0, mcyc = 0, last_rise = 0;
  int         per_min = 0, per_max = 0;
  logic [8:0] sr = 9'd0;
  logic [7:0] dec_q[$];
  int         rises_q[$];

  always @(negedge clk_i) begin
    logic scl_l, sda_l;
    mcyc++;
    scl_l = ~scl_oe_o;
    sda_l = sda_i;
    if (scl_l && prev_scl) begin
      if (prev_sda && !sda_l) begin
        starts++;  bitcnt = 0;  rises = 0;  per_min = 1 << 30;  per_max = 0;
      end else if (!prev_sda && sda_l) begin
        stops++;
        rises_q.push_back(rises);
      end
    end
    if (scl_l && !prev_scl) begin
      rises++;
      if (bitcnt != 0) begin
        if (mcyc - last_rise < per_min) per_min = mcyc - last_rise;
        if (mcyc - last_rise > per_max) per_max = mcyc - last_rise;
      end
      last_rise = mcyc;
      sr = {sr[7:0], sda_l};
      bitcnt++;
      if (bitcnt == 9) begin
        dec_q.push_back(sr[8:1]);
        bitcnt = 0;
      end
    end
    prev_scl = scl_l;
    prev_sda = sda_l;
  end

  int acc_cnt = 0, done_cnt = 0, nack_cnt = 0;
  int a0 = 0, d0 = 0, n0 = 0;
  always @(posedge clk_i) begin
    if (arstn_i) begin
      if (cfg_valid_i && cfg_ready_o) acc_cnt++;
      if (done_o) done_cnt++;
      if (nack_o) nack_cnt++;
    end
  end

  task automatic clear_dec();
    starts = 0;  stops = 0;
    dec_q.delete();
    rises_q.delete();
    a0 = acc_cnt;  d0 = done_cnt;  n0 = nack_cnt;
  endtask

  task automatic accept_word(input logic [23:0] w, input int ntx, input int nb);
    @(posedge clk_i);
    #1;
    cfg_valid_i = 1'b1;
    cfg_data_i  = w;
    @(posedge clk_i);
    model_word(w, ntx, nb);
    #1;
    cfg_valid_i = 1'b0;
  endtask

  task automatic wait_done(input bit jitter);
    int g;
    g = 0;
    if (jitter) cfg_valid_i = 1'b1;
    while (exp_q.size() > 1 && g < 20000) begin
      if (jitter) cfg_data_i = 24'($urandom);
      @(posedge clk_i);
      #1;
      g++;
    end
    cfg_valid_i = 1'b0;
    while (exp_q.size() != 0 && g < 20000) begin
      @(posedge clk_i);
      #1;
      g++;
    end
    n_checks++;
    if (g >= 20000) begin
      n_errors++;
      $display("FAIL word_timeout got %0d pending want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic send_word(input logic [23:0] w, input int ntx, input int nb, input bit jitter);
    clear_dec();
    accept_word(w, ntx, nb);
    wait_done(jitter);
  endtask

  task automatic post_check(input string nm, input int nb, input logic [47:0] eb, input int ntx,
                            input int last_r, input int nnack);
    check_int({nm, "_nbytes"}, dec_q.size(), nb);
    for (int i = 0; i < nb && i < dec_q.size(); i++)
      check_int($sformatf("%s_byte%0d", nm, i), int'(dec_q[i]), int'(eb[8*(nb-1-i) +: 8]));
    check_int({nm, "_starts"}, starts, ntx);
    check_int({nm, "_stops"}, stops, ntx);
    for (int i = 0; i < rises_q.size(); i++)
      check_int($sformatf("%s_rises%0d", nm, i), rises_q[i], (i == rises_q.size() - 1) ? last_r : 28);
    check_int({nm, "_scl_period_min"}, per_min, 20);
    check_int({nm, "_scl_period_max"}, per_max, 20);
    check_int({nm, "_accepts"}, acc_cnt - a0, 1);
    check_int({nm, "_dones"}, done_cnt - d0, 1);
    check_int({nm, "_nacks"}, nack_cnt - n0, nnack);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk_i);
    #1;
    check_int("rst_outputs", int'({scl_oe_o, sda_oe_o, cfg_ready_o, busy_o, done_o, nack_o}), 8);
    arstn_i = 1'b1;
    mon_en  = 1'b1;
    clear_dec();
    repeat (10000) @(posedge clk_i);
    #1;
    check_int("idle_starts", starts, 0);
    check_int("idle_rises", rises_q.size(), 0);

    send_word(24'h00_0B_24, 0, -1, 1'b0);
    post_check("w1", 6, 48'hE8_01_00_E8_0B_24, 2, 28, 0);

    send_word(24'h00_0C_11, 0, -1, 1'b0);
    post_check("w2", 3, 48'hE8_0C_11, 1, 28, 0);

    send_word(24'h05_20_AA, 0, -1, 1'b0);
    post_check("w3", 6, 48'hE8_01_05_E8_20_AA, 2, 28, 0);

    send_word(24'h05_33_77, 2, 0, 1'b0);
    post_check("w4_nack", 1, 48'hE8, 1, 10, 1);

    send_word(24'h05_12_34, 0, -1, 1'b0);
    post_check("w5", 6, 48'hE8_01_05_E8_12_34, 2, 28, 0);

    send_word(24'h05_44_55, 0, -1, 1'b1);
    post_check("w6_hold", 3, 48'hE8_44_55, 1, 28, 0);

    // Abort inside bit 3 of the address byte (SCL low, SDA low for a 0 bit).
    clear_dec();
    accept_word(24'h05_66_77, 0, -1);
    repeat (70) @(posedge clk_i);
    #1;
    check_int("pre_rst_oe", int'({scl_oe_o, sda_oe_o}), 3);
    #1;
    mon_en  = 1'b0;
    arstn_i = 1'b0;
    exp_q.delete();
    m_vld = 1'b0;
    #1;
    check_int("rst_async_oe", int'({scl_oe_o, sda_oe_o}), 0);
    repeat (3) @(posedge clk_i);
    #1;
    arstn_i = 1'b1;
    mon_en  = 1'b1;

    send_word(24'h05_66_77, 0, -1, 1'b0);
    post_check("w8_after_rst", 6, 48'hE8_01_05_E8_66_77, 2, 28, 0);

    repeat (20) @(posedge clk_i);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
